// File: rtl/counter_reload_arbiter.sv
// counter_reload_arbiter: round-robin owner selection for a shared self-reloading counter
module counter_reload_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0]         count_i,
   output logic                     load_o,
   output logic [WIDTH-1:0]         load_val_o,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [NUM_REQ-1:0]       done_o,
   output logic                     busy_o
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [WIDTH-1:0] MAX = '1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t            state, state_d;
   logic [IW-1:0]     ptr, ptr_d, idx, idx_d, win;
   logic [WIDTH-1:0]  val_q, val_d;
   logic [WIDTH-1:0]  vals [NUM_REQ];
   logic              at_max;

   assign at_max = count_i == MAX;

   // first requester at or after ptr, wrapping; lowest rotation offset wins
   always_comb begin
      win = ptr;
      for (int i = 0; i < NUM_REQ; i++)
         vals[i] = load_val_i[i*WIDTH +: WIDTH];
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (req_i[IW'((int'(ptr) + i) % NUM_REQ)]) win = IW'((int'(ptr) + i) % NUM_REQ);
   end

   // next state, grant capture at arbitration and pointer advance on completion
   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      idx_d   = idx;
      val_d   = val_q;
      if (state == IDLE && |req_i) begin
         state_d = LOAD;
         idx_d   = win;
         val_d   = vals[win];
      end else if (state == LOAD) begin
         state_d = RUN;
      end else if (state == RUN && at_max) begin
         state_d = IDLE;
         ptr_d   = (idx == IW'(NUM_REQ-1)) ? '0 : idx + 1'b1;
      end
   end

   // state register; reset aborts any job in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= '0;
         idx   <= '0;
         val_q <= '0;
      end else begin
         state <= state_d;
         ptr   <= ptr_d;
         idx   <= idx_d;
         val_q <= val_d;
      end
   end

   assign busy_o     = state != IDLE;
   assign load_o     = state == LOAD;
   assign load_val_o = (state == LOAD) ? val_q : '0;
   assign gnt_o      = (state != IDLE) ? NUM_REQ'(1) << idx : '0;
   assign done_o     = (state == RUN && at_max) ? NUM_REQ'(1) << idx : '0;
endmodule
